int_exec_cdb_stage: RTL and testbench
=====================================

Name: int_exec_cdb_stage

Overview:
- Integer execution stage directly downstream of the integer issue queue.
- Accepts one issued instruction per handshake: opcode, rd tag, two 32-bit operands.
- Executes single-cycle ALU ops and a multi-cycle multiply, then holds the result in an output register until the common data bus (CDB) arbiter grants it.
- The granted tag/data pair is the CDB broadcast that wakes up queue entries and feeds CDB_data.

Parameters:
- MUL_LAT, 4, multiply latency in cycles from issue accept to cdb_req (legal 2..15).
- TAG_W, 6, rd tag width.
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of in-flight/held op (branch mispredict).
- issue_valid  in  1  issue queue presents an instruction.
- issue_ready  out  1  stage can accept this cycle.
- issue_opcode  in  4  operation code.
- issue_rd_tag  in  TAG_W  destination tag.
- issue_rs1_data  in  DATA_W  operand A.
- issue_rs2_data  in  DATA_W  operand B.
- cdb_req  out  1  result waiting for CDB.
- cdb_grant  in  1  arbiter grant, meaningful only while cdb_req=1.
- cdb_tag  out  TAG_W  result tag.
- cdb_data  out  DATA_W  result value.
- cdb_exc  out  1  illegal-opcode flag travelling with the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous on reset=0. State=IDLE, cdb_req=0, cdb_tag=0, cdb_data=0, cdb_exc=0, mul counter=0, busy=0, issue_ready=1 once reset deasserts.
- Accept: fires when issue_valid & issue_ready at the rising edge.
- issue_ready = (state==IDLE) | (state==WAIT_CDB & cdb_grant). Held low during MUL_BUSY and while flush=1.
- Opcodes (rs1 op rs2), 32-bit wrap arithmetic:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = rs2[4:0].
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
  - 10 MUL: low 32 bits of the product.
  - 11..15 illegal: result 0, cdb_exc=1.
- State machine:
  - IDLE: accept of a single-cycle op -> WAIT_CDB. Result, tag and exc are registered at the accept edge, so cdb_req=1 the next cycle (latency 1).
  - IDLE: accept of MUL -> MUL_BUSY. Operands and tag are latched and the counter is loaded with MUL_LAT-1.
  - MUL_BUSY: counter decrements each cycle. At 0, the product is registered and state -> WAIT_CDB. cdb_req rises exactly MUL_LAT cycles after the accept edge.
  - WAIT_CDB: cdb_req=1 and cdb_tag/cdb_data/cdb_exc are stable until granted.
  - WAIT_CDB, grant without a new accept -> IDLE, cdb_req=0 next cycle.
  - WAIT_CDB, grant with a simultaneous accept: back-to-back. The new op is processed as if accepted from IDLE; a single-cycle op keeps cdb_req=1 with the new values the next cycle.
- Flush: synchronous. Highest priority over accept and grant. Next state=IDLE, cdb_req=0, in-flight MUL is discarded. cdb_tag/cdb_data keep their values; they are don't-care when cdb_req=0.
- Reset asserted mid-MUL or mid-WAIT_CDB: immediately returns all state to reset values; no stale broadcast after release.
- cdb_grant while cdb_req=0 is ignored.

Optional Feature:
- Macro INT_EXEC_MUL_EN.
- Defined: MUL datapath and MUL_BUSY state are present as above.
- Undefined: no multiplier and no MUL_BUSY state. Opcode 10 is treated as illegal (single-cycle, result 0, cdb_exc=1). MUL_LAT is unused.

Test Plan:
- Reset release, then issue ADD rs1=0x7FFFFFFF rs2=1 tag=5 -> next cycle cdb_req=1, cdb_tag=5, cdb_data=0x80000000, cdb_exc=0.
- Hold cdb_grant=0 for 3 cycles after a SUB 3-5 tag=9 -> cdb_data=0xFFFFFFFE stable, issue_ready=0. Grant -> cdb_req=0 next cycle, issue_ready=1.
- With INT_EXEC_MUL_EN and MUL_LAT=4: MUL 0x10000 x 0x10001 tag=12 accepted at cycle T -> issue_ready=0 for cycles T+1..T+4; cdb_req rises at T+4 with cdb_data=0x00010000 (0x100010000 truncated to 32 bits).
- In WAIT_CDB holding SRA 0x80000000 >>4 (result 0xF8000000), grant and issue SLTU 1<0xFFFFFFFF tag=3 in the same cycle -> next cycle cdb_req=1, cdb_tag=3, cdb_data=1.
- Flush during MUL_BUSY (2 cycles after accept) -> cdb_req never rises, state IDLE and issue_ready=1 the next cycle. Same test with reset=0 pulse instead gives the same outcome asynchronously.
- Opcode 13 tag=7 -> cdb_req=1, cdb_data=0, cdb_exc=1. Without INT_EXEC_MUL_EN, opcode 10 gives the same response.

Source files
------------

// File: rtl/int_exec_cdb_stage_if.sv
// Issue-side and CDB-side handshake bundle for int_exec_cdb_stage.
// slave = execution stage, master = issue queue / CDB arbiter side.
interface int_exec_cdb_stage_if #(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic              cdb_req;
  logic              cdb_grant;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_exc;

  modport master (
    output issue_valid, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data,
    output cdb_grant,
    input  issue_ready, cdb_req, cdb_tag, cdb_data, cdb_exc
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data,
    input  cdb_grant,
    output issue_ready, cdb_req, cdb_tag, cdb_data, cdb_exc
  );
endinterface

// File: rtl/int_exec_cdb_stage.sv
// Integer execute stage: single-cycle ALU plus optional multi-cycle MUL, result held until CDB grant.
// Define INT_EXEC_MUL_EN to include the multiplier and MUL_BUSY state; otherwise opcode 10 is illegal.
module int_exec_cdb_stage #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  int_exec_cdb_stage_if.slave   bus,
  output logic                  busy
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_mul_lat_check
    $error("int_exec_cdb_stage: MUL_LAT must be in 2..15");
  end

`ifdef INT_EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL_BUSY, WAIT_CDB} state_t;
`else
  typedef enum logic [0:0] {IDLE, WAIT_CDB} state_t;
`endif

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  state_t            state, state_nx, issue_target;
  logic              accept, is_mul;
  logic [DATA_W-1:0] alu_res;
  logic              alu_exc;
  logic [4:0]        shamt;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic              res_exc;

  assign accept = bus.issue_valid & bus.issue_ready;
  assign shamt  = bus.issue_rs2_data[4:0];

`ifdef INT_EXEC_MUL_EN
  logic [3:0]        mul_cnt;
  logic [DATA_W-1:0] mul_a, mul_b, mul_prod;
  logic [TAG_W-1:0]  mul_tag;
  logic              mul_done;

  assign is_mul       = (bus.issue_opcode == OP_MUL);
  assign issue_target = is_mul ? MUL_BUSY : WAIT_CDB;
  assign mul_prod     = mul_a * mul_b;
  assign mul_done     = (state == MUL_BUSY) && (mul_cnt == '0);
`else
  assign is_mul       = 1'b0;
  assign issue_target = WAIT_CDB;
`endif

  always_comb begin
    alu_res = '0;
    alu_exc = 1'b0;
    case (bus.issue_opcode)
      OP_ADD:  alu_res = bus.issue_rs1_data + bus.issue_rs2_data;
      OP_SUB:  alu_res = bus.issue_rs1_data - bus.issue_rs2_data;
      OP_AND:  alu_res = bus.issue_rs1_data & bus.issue_rs2_data;
      OP_OR:   alu_res = bus.issue_rs1_data | bus.issue_rs2_data;
      OP_XOR:  alu_res = bus.issue_rs1_data ^ bus.issue_rs2_data;
      OP_SLL:  alu_res = bus.issue_rs1_data << shamt;
      OP_SRL:  alu_res = bus.issue_rs1_data >> shamt;
      OP_SRA:  alu_res = $signed(bus.issue_rs1_data) >>> shamt;
      OP_SLT:  alu_res = DATA_W'($signed(bus.issue_rs1_data) < $signed(bus.issue_rs2_data));
      OP_SLTU: alu_res = DATA_W'(bus.issue_rs1_data < bus.issue_rs2_data);
      default: alu_exc = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // A grant in WAIT_CDB frees the output register, so a same-cycle accept is handled as from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = issue_target;
`ifdef INT_EXEC_MUL_EN
      MUL_BUSY: if (mul_cnt == '0) state_nx = WAIT_CDB;
`endif
      WAIT_CDB: if (bus.cdb_grant) state_nx = accept ? issue_target : IDLE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    bus.issue_ready = 1'b0;
    bus.cdb_req     = 1'b0;
    busy            = 1'b0;
    case (state)
      IDLE:     bus.issue_ready = !flush;
      WAIT_CDB: begin
        bus.issue_ready = bus.cdb_grant & !flush;
        bus.cdb_req     = 1'b1;
        busy            = 1'b1;
      end
      default:  busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_tag  <= '0;
      res_data <= '0;
      res_exc  <= 1'b0;
    end else if (!flush) begin
      if (accept && !is_mul) begin
        res_tag  <= bus.issue_rd_tag;
        res_data <= alu_res;
        res_exc  <= alu_exc;
      end
`ifdef INT_EXEC_MUL_EN
      else if (mul_done) begin
        res_tag  <= mul_tag;
        res_data <= mul_prod;
        res_exc  <= 1'b0;
      end
`endif
    end
  end

`ifdef INT_EXEC_MUL_EN
  // Counter is loaded with MUL_LAT-1 and the product lands on the edge after it reaches 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_tag <= '0;
    end else if (flush) begin
      mul_cnt <= '0;
    end else if (accept && is_mul) begin
      mul_cnt <= 4'(MUL_LAT - 1);
      mul_a   <= bus.issue_rs1_data;
      mul_b   <= bus.issue_rs2_data;
      mul_tag <= bus.issue_rd_tag;
    end else if (state == MUL_BUSY && mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 4'd1;
    end
  end
`endif

  assign bus.cdb_tag  = res_tag;
  assign bus.cdb_data = res_data;
  assign bus.cdb_exc  = res_exc;

endmodule

// File: tb/tb_int_exec_cdb_stage.sv
// Self-checking bench for int_exec_cdb_stage: vector table, corner sequences, randomized run vs. model.
// Follows INT_EXEC_MUL_EN the same way the design does.
module tb_int_exec_cdb_stage;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int_exec_cdb_stage_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  int_exec_cdb_stage #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        exc;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] tag,
                       input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid    = v;
    bus.issue_opcode   = op;
    bus.issue_rd_tag   = tag;
    bus.issue_rs1_data = a;
    bus.issue_rs2_data = b;
  endtask

  function automatic logic model_is_mul(input logic [3:0] op);
`ifdef INT_EXEC_MUL_EN
    return op == 4'd10;
`else
    return 1'b0;
`endif
  endfunction

  // Returns {exc, data} from the opcode definitions using plain arithmetic.
  function automatic logic [32:0] ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] wide;
    int unsigned s;
    s = b[4:0];
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a + ~b + 32'd1};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, a << s};
      4'd6: return {1'b0, a >> s};
      4'd7: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
        return {1'b0, r};
      end
      4'd8: return {1'b0, 31'd0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))};
      4'd9: return {1'b0, 31'd0, (a < b)};
`ifdef INT_EXEC_MUL_EN
      4'd10: begin
        wide = {32'd0, a} * {32'd0, b};
        return {1'b0, wide[31:0]};
      end
`endif
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend_v;
    logic [5:0]  pend_tag;
    logic [31:0] pend_data;
    logic        pend_exc;
    logic [5:0]  mul_tag_m;
    logic [31:0] mul_data_m;
    int          mul_left;
    logic        v, g, f, exp_ready, acc;
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [31:0] a, b;
    logic [32:0] res;

    vt.push_back('{4'd0,  6'd5,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
    vt.push_back('{4'd1,  6'd9,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0});
    vt.push_back('{4'd2,  6'd1,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0});
    vt.push_back('{4'd3,  6'd2,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0});
    vt.push_back('{4'd4,  6'd63, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0});
    vt.push_back('{4'd5,  6'd4,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0});
    vt.push_back('{4'd6,  6'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0});
    vt.push_back('{4'd7,  6'd8,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0});
    vt.push_back('{4'd8,  6'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    vt.push_back('{4'd9,  6'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vt.push_back('{4'd8,  6'd12, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});
    vt.push_back('{4'd13, 6'd7,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1});
    vt.push_back('{4'd15, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});

    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    bus.cdb_grant = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",  bus.cdb_req,  0);
    chk("rst_tag",  bus.cdb_tag,  0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_exc",  bus.cdb_exc,  0);
    chk("rst_busy", busy,         0);
    reset = 1'b1;
    #1;
    chk("rst_ready", bus.issue_ready, 1);
    tick();

    // Table of single-cycle ops from IDLE
    foreach (vt[i]) begin
      drive(1'b1, vt[i].op, vt[i].tag, vt[i].a, vt[i].b);
      tick();
      drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
      #1;
      chk($sformatf("vec%0d_req",   i), bus.cdb_req,     1);
      chk($sformatf("vec%0d_tag",   i), bus.cdb_tag,     vt[i].tag);
      chk($sformatf("vec%0d_data",  i), bus.cdb_data,    vt[i].data);
      chk($sformatf("vec%0d_exc",   i), bus.cdb_exc,     vt[i].exc);
      chk($sformatf("vec%0d_ready", i), bus.issue_ready, 0);
      bus.cdb_grant = 1'b1;
      tick();
      bus.cdb_grant = 1'b0;
      #1;
      chk($sformatf("vec%0d_req_after", i), bus.cdb_req, 0);
    end

    // SUB held without grant
    drive(1'b1, 4'd1, 6'd9, 32'd3, 32'd5);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_req",   bus.cdb_req,     1);
      chk("hold_data",  bus.cdb_data,    32'hFFFF_FFFE);
      chk("hold_ready", bus.issue_ready, 0);
      tick();
    end
    bus.cdb_grant = 1'b1;
    #1;
    chk("grant_ready_same", bus.issue_ready, 1);
    tick();
    bus.cdb_grant = 1'b0;
    #1;
    chk("grant_req_next",   bus.cdb_req,     0);
    chk("grant_ready_next", bus.issue_ready, 1);

    // Opcode 10
    drive(1'b1, 4'd10, 6'd12, 32'h0001_0000, 32'h0001_0001);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
`ifdef INT_EXEC_MUL_EN
    for (int k = 0; k < int'(MUL_LAT); k++) begin
      #1;
      chk($sformatf("mul_ready_c%0d", k), bus.issue_ready, 0);
      chk($sformatf("mul_req_c%0d",   k), bus.cdb_req,     0);
      chk($sformatf("mul_busy_c%0d",  k), busy,            1);
      tick();
    end
    chk("mul_req",  bus.cdb_req,  1);
    chk("mul_tag",  bus.cdb_tag,  12);
    chk("mul_data", bus.cdb_data, 32'h0001_0000);
    chk("mul_exc",  bus.cdb_exc,  0);
`else
    chk("op10_req",  bus.cdb_req,  1);
    chk("op10_tag",  bus.cdb_tag,  12);
    chk("op10_data", bus.cdb_data, 0);
    chk("op10_exc",  bus.cdb_exc,  1);
`endif
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;

    // Back-to-back grant + accept
    drive(1'b1, 4'd7, 6'd20, 32'h8000_0000, 32'd4);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    #1;
    chk("b2b_first_data", bus.cdb_data, 32'hF800_0000);
    bus.cdb_grant = 1'b1;
    drive(1'b1, 4'd9, 6'd3, 32'd1, 32'hFFFF_FFFF);
    #1;
    chk("b2b_ready", bus.issue_ready, 1);
    tick();
    bus.cdb_grant = 1'b0;
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    #1;
    chk("b2b_req",  bus.cdb_req,  1);
    chk("b2b_tag",  bus.cdb_tag,  3);
    chk("b2b_data", bus.cdb_data, 1);
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;

    // Flush of an in-flight op
`ifdef INT_EXEC_MUL_EN
    drive(1'b1, 4'd10, 6'd30, 32'd7, 32'd9);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    tick();
`else
    drive(1'b1, 4'd0, 6'd30, 32'd7, 32'd9);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
`endif
    flush = 1'b1;
    bus.cdb_grant = 1'b1;
    drive(1'b1, 4'd0, 6'd31, 32'd1, 32'd1);
    #1;
    chk("flush_ready_low", bus.issue_ready, 0);
    tick();
    flush = 1'b0;
    bus.cdb_grant = 1'b0;
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    #1;
    chk("flush_busy",  busy,            0);
    chk("flush_ready", bus.issue_ready, 1);
    for (int k = 0; k < 6; k++) begin
      chk("flush_no_req", bus.cdb_req, 0);
      tick();
    end

    // Asynchronous reset mid-operation
`ifdef INT_EXEC_MUL_EN
    drive(1'b1, 4'd10, 6'd33, 32'd5, 32'd6);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    tick();
`else
    drive(1'b1, 4'd3, 6'd33, 32'h55, 32'hAA00);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy,        0);
    chk("arst_req",  bus.cdb_req, 0);
    chk("arst_tag",  bus.cdb_tag, 0);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("arst_no_req", bus.cdb_req, 0);
    end

    // Reset during WAIT_CDB
    drive(1'b1, 4'd0, 6'd21, 32'h1111, 32'h2222);
    tick();
    drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
    #1;
    chk("wrst_req_before", bus.cdb_req, 1);
    reset = 1'b0;
    #1;
    chk("wrst_req",  bus.cdb_req,  0);
    chk("wrst_data", bus.cdb_data, 0);
    #1;
    reset = 1'b1;
    tick();
    chk("wrst_req_after", bus.cdb_req, 0);

    // Grant while idle is ignored
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    #1;
    chk("idle_grant_req",  bus.cdb_req, 0);
    chk("idle_grant_busy", busy,        0);

    // Randomized run against the transaction-level model
    pend_v = 1'b0; pend_tag = '0; pend_data = '0; pend_exc = 1'b0;
    mul_tag_m = '0; mul_data_m = '0; mul_left = 0;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      g   = ($urandom_range(0, 1) != 0);
      f   = ($urandom_range(0, 19) == 0);
      op  = ($urandom_range(0, 4) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      tag = 6'($urandom);
      a   = pick();
      b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : pick();
      drive(v, op, tag, a, b);
      bus.cdb_grant = g;
      flush = f;
      #1;
      exp_ready = !f && (mul_left == 0) && (!pend_v || g);
      chk("rnd_ready", bus.issue_ready, exp_ready);
      chk("rnd_req",   bus.cdb_req,     pend_v);
      chk("rnd_busy",  busy,            pend_v || (mul_left != 0));
      if (pend_v) begin
        chk("rnd_tag",  bus.cdb_tag,  pend_tag);
        chk("rnd_data", bus.cdb_data, pend_data);
        chk("rnd_exc",  bus.cdb_exc,  pend_exc);
      end
      acc = v && exp_ready;
      if (f) begin
        pend_v   = 1'b0;
        mul_left = 0;
      end else begin
        if (pend_v && g) pend_v = 1'b0;
        if (mul_left > 0) begin
          mul_left--;
          if (mul_left == 0) begin
            pend_v = 1'b1; pend_tag = mul_tag_m; pend_data = mul_data_m; pend_exc = 1'b0;
          end
        end
        if (acc) begin
          res = ref_exec(op, a, b);
          if (model_is_mul(op)) begin
            mul_left = MUL_LAT; mul_tag_m = tag; mul_data_m = res[31:0];
          end else begin
            pend_v = 1'b1; pend_tag = tag; pend_data = res[31:0]; pend_exc = res[32];
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
